// File: rtl/seq_cone_monitor.sv
// Pipelined per-channel boolean function with a consecutive
// all-ones match counter and a sticky threshold trigger.
module seq_cone_monitor #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             blk_clk,
  input  logic             blk_rst,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] thresh,
  input  logic             trig_clr,
  output logic [WIDTH-1:0] out_q,
  output logic             out_vld,
  output logic             trig,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] f;
  logic [DEPTH-1:0][WIDTH-1:0] dat_q, dat_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic trig_q, trig_d;
  logic match;

  always_comb begin
    f = '0;
    case (mode)
      2'b00:   f = in_a & in_b;
      2'b01:   f = ~(in_a | in_b);
      2'b10:   f = in_a ^ in_c;
      default: f = (in_a & in_b) | ~in_c;
    endcase
  end

  // Stage 0 holds its last sample while idle, so the tail of the
  // pipe keeps showing the last valid result through bubbles.
  always_comb begin
    dat_d = dat_q;
    vld_d = vld_q;
    dat_d[0] = in_en ? f : dat_q[0];
    vld_d[0] = in_en;
    for (int i = 1; i < DEPTH; i++) begin
      dat_d[i] = dat_q[i-1];
      vld_d[i] = vld_q[i-1];
    end
  end

  assign out_q   = dat_q[DEPTH-1];
  assign out_vld = vld_q[DEPTH-1];
  assign match   = out_vld & (&out_q);

  always_comb begin
    cnt_d = cnt_q;
    if (trig_clr) begin
      cnt_d = '0;
    end else if (match) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end else if (out_vld) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    trig_d = trig_q;
    if (trig_clr) begin
      trig_d = 1'b0;
    end else if ((thresh != '0) && (cnt_d >= thresh)) begin
      trig_d = 1'b1;
    end
  end

  always_ff @(posedge blk_clk or posedge blk_rst) begin
    if (blk_rst) begin
      dat_q  <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      dat_q  <= dat_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
    end
  end

  assign trig      = trig_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_cone_monitor.sv
// Scoreboard bench for seq_cone_monitor: stimulus pushes expected
// results, a negedge monitor pops and checks outputs and counter.
module tb_seq_cone_monitor;
  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_en = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0, c = '0;
  logic [1:0] mode = '0;
  logic [CNT_W-1:0] thresh = '0;
  logic clr = 1'b0;
  logic [WIDTH-1:0] out_q;
  logic out_vld, trig;
  logic [CNT_W-1:0] match_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [WIDTH-1:0] exp_dat[$];
  int exp_due[$];
  logic [WIDTH-1:0] m_last = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic m_trig = 1'b0;
  logic ev, mt;
  logic [WIDTH-1:0] ed;

  seq_cone_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .blk_clk(clk), .blk_rst(rst), .in_en(in_en),
    .in_a(a), .in_b(b), .in_c(c), .mode(mode),
    .thresh(thresh), .trig_clr(clr),
    .out_q(out_q), .out_vld(out_vld),
    .trig(trig), .match_cnt(match_cnt)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [WIDTH-1:0] ref_f(
    input logic [1:0] m, input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (m)
        2'd0: r[i] = x[i] && y[i];
        2'd1: r[i] = !(x[i] || y[i]);
        2'd2: r[i] = (x[i] != z[i]);
        default: r[i] = (x[i] && y[i]) || !z[i];
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb, input logic [WIDTH-1:0] vc,
                       input logic [1:0] vm, input logic [CNT_W-1:0] thr,
                       input logic vclr);
    @(posedge clk);
    #1;
    in_en = en; a = va; b = vb; c = vc;
    mode = vm; thresh = thr; clr = vclr;
    if (en) begin
      exp_dat.push_back(ref_f(vm, va, vb, vc));
      exp_due.push_back(cyc + DEPTH);
    end
  endtask

  task automatic ones(input int n, input logic [CNT_W-1:0] thr);
    for (int i = 0; i < n; i++) drive(1'b1, ONES, ONES, '0, 2'd0, thr, 1'b0);
  endtask

  task automatic idle(input int n, input logic [CNT_W-1:0] thr);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, 2'd0, thr, 1'b0);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #1 in_en = 1'b0; clr = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_out_q", out_q, 0);
    check("rst_out_vld", out_vld, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_trig", trig, 0);
    exp_dat.delete();
    exp_due.delete();
    m_cnt = '0; m_trig = 1'b0; m_last = '0;
    #1 rst = 1'b0;
  endtask

  // Monitor: model of what the outputs must be after each edge
  initial forever begin
    @(negedge clk);
    while (exp_due.size() > 0 && exp_due[0] < cyc) begin
      checks++; errors++;
      $display("FAIL latency: sample due cyc %0d missed at cyc %0d",
               exp_due[0], cyc);
      void'(exp_due.pop_front());
      void'(exp_dat.pop_front());
    end
    ev = 1'b0;
    ed = m_last;
    if (exp_due.size() > 0 && exp_due[0] == cyc) begin
      ev = 1'b1;
      ed = exp_dat.pop_front();
      void'(exp_due.pop_front());
    end
    check("out_vld", out_vld, ev);
    check("out_q", out_q, ed);
    check("match_cnt", match_cnt, m_cnt);
    check("trig", trig, m_trig);
    m_last = ed;
    mt = ev && (ed == ONES);
    if (clr) m_cnt = '0;
    else if (mt) m_cnt = (m_cnt == CMAX) ? m_cnt : m_cnt + 1'b1;
    else if (ev) m_cnt = '0;
    if (clr) m_trig = 1'b0;
    else if (thresh != 0 && m_cnt >= thresh) m_trig = 1'b1;
  end

  initial begin
    #1;
    check("init_out_q", out_q, 0);
    check("init_out_vld", out_vld, 0);
    check("init_cnt", match_cnt, 0);
    check("init_trig", trig, 0);
    #20 rst = 1'b0;

    // single pulse, mode 00 all ones
    drive(1'b1, 4'hF, 4'hF, 4'h0, 2'd0, 4'd0, 1'b0);
    idle(4, 4'd0);
    // threshold 3 then one mismatch
    ones(3, 4'd3);
    drive(1'b1, 4'h0, 4'hF, 4'h0, 2'd0, 4'd3, 1'b0);
    idle(4, 4'd3);
    // mode switch with capture-time function
    drive(1'b1, 4'hA, 4'hF, 4'h5, 2'd0, 4'd3, 1'b0);
    drive(1'b1, 4'hA, 4'hF, 4'h5, 2'd2, 4'd3, 1'b0);
    idle(4, 4'd3);
    // clear coincident with a match
    ones(2, 4'd2);
    drive(1'b1, ONES, ONES, '0, 2'd0, 4'd2, 1'b1);
    drive(1'b1, ONES, ONES, '0, 2'd0, 4'd2, 1'b1);
    idle(4, 4'd2);
    drive(1'b0, '0, '0, '0, 2'd0, 4'd0, 1'b1);
    // thresh 0 and saturation
    ones(20, 4'd0);
    idle(3, 4'd0);
    // lowering thresh fires on next edge
    idle(2, 4'd15);
    idle(2, 4'd14);
    drive(1'b0, '0, '0, '0, 2'd0, 4'd0, 1'b1);
    // reset with samples in flight
    ones(2, 4'd0);
    mid_reset();
    idle(4, 4'd0);

    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] ra, rb, rc;
      logic [1:0] rm;
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = WIDTH'($urandom);
      rm = 2'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        ra = ONES; rb = ONES; rm = 2'd0;
      end
      if ($urandom_range(0, 15) == 0) thresh = CNT_W'($urandom_range(0, 6));
      drive($urandom_range(0, 3) != 0, ra, rb, rc, rm, thresh,
            $urandom_range(0, 24) == 0);
      if (i == 200) mid_reset();
    end

    idle(DEPTH + 3, 4'd0);
    check("drain", exp_due.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_cone_monitor.md
SEQ_CONE_MONITOR -- requirements
Module: seq_cone_monitor

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 4, legal range 1..32, giving the number of bit-channels.
REQ-002 The block SHALL have parameter DEPTH, default 2, legal range 1..8, giving the number of register stages from input to output.
REQ-003 The block SHALL have parameter CNT_W, default 4, legal range 2..8, giving the width of the match counter.

Interface
REQ-004 blk_clk  input  1  Single clock; all state updates on its rising edge.
REQ-005 blk_rst  input  1  Reset; asynchronous and active-high.
REQ-006 in_en  input  1  Sample qualifier; inputs are captured only when high.
REQ-007 in_a  input  WIDTH  Operand A, one bit per channel.
REQ-008 in_b  input  WIDTH  Operand B, one bit per channel.
REQ-009 in_c  input  WIDTH  Operand C, one bit per channel.
REQ-010 mode  input  2  Per-sample function select.
REQ-011 thresh  input  CNT_W  Number of consecutive matches that fires the trigger; 0 disables it.
REQ-012 trig_clr  input  1  Synchronous clear of the trigger and the counter.
REQ-013 out_q  output  WIDTH  Pipelined function result.
REQ-014 out_vld  output  1  High when out_q holds a valid result.
REQ-015 trig  output  1  Sticky trigger flag.
REQ-016 match_cnt  output  CNT_W  Current consecutive-match count.

Function
REQ-017 Stage 0 SHALL compute f per channel i from mode:
- 00: a&b
- 01: ~(a|b)
- 10: a^c
- 11: (a&b)|~c
REQ-018 Stage 0 SHALL register f and a valid bit equal to in_en on each rising edge.
REQ-019 Stages 1..DEPTH-1 SHALL shift data and valid forward every cycle, unconditionally, so bubbles propagate.
REQ-020 out_q/out_vld SHALL be the last stage, giving a latency of exactly DEPTH cycles from an in_en-high edge to out_vld high.
REQ-021 The function SHALL be fixed at capture time; a mode change SHALL NOT alter samples already in flight.
REQ-022 out_q SHALL hold its previous value when out_vld is low.
REQ-023 A match SHALL be defined as out_vld=1 and out_q all-ones.
REQ-024 Each cycle the counter SHALL update by the first rule that applies:
- trig_clr=1 -> 0
- match -> increment, saturating at 2^CNT_W-1
- out_vld=1 and not a match -> 0
- out_vld=0 -> hold
REQ-025 trig SHALL go high on the edge where thresh!=0 and the next counter value is >= thresh.
REQ-026 Once high, trig SHALL stay high until trig_clr or reset.
REQ-027 When trig_clr and a match occur in the same cycle, the clear SHALL win and trig SHALL be 0 on the next cycle.
REQ-028 thresh SHALL be sampled every cycle; lowering thresh below the current count SHALL fire trig on the next edge.
REQ-029 The counter SHALL saturate, never wrap; trig SHALL remain asserted through saturation.

Reset
REQ-030 While blk_rst=1, asynchronously and without waiting for a clock edge:
- all pipeline data and valid bits SHALL be 0
- out_q=0, out_vld=0, match_cnt=0, trig=0
REQ-031 Reset asserted mid-operation SHALL discard in-flight samples; none SHALL emerge after release.
REQ-032 On the first edge after release, stage 0 SHALL accept new input normally.

Verification
REQ-033 DEPTH=2, mode=00, a=b=4'hF, in_en pulsed 1 cycle -> out_q=4'hF and out_vld=1 exactly 2 cycles later for 1 cycle; match_cnt=1.
REQ-034 thresh=3, three back-to-back all-ones samples -> trig rises with match_cnt=3; one mismatch sample follows -> match_cnt=0 and trig stays 1.
REQ-035 mode toggled 00->10 on consecutive samples with a=4'hA, b=4'hF, c=4'h5 -> outputs 4'hA then 4'hF, in order.
REQ-036 Match and trig_clr in the same cycle -> next cycle match_cnt=0, trig=0; thresh=0 with 20 matches -> trig never rises and match_cnt saturates at 15.
REQ-037 blk_rst pulsed between clock edges with 2 samples in flight -> outputs 0 immediately; no out_vld pulse after release.
